// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment scanner: frame-synchronous latching, leading-zero
// blanking, per-digit decimal points, 16-step PWM brightness and whole-display blink.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 25000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_display_value,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic                    i_blank_lz,
  input  logic                    i_blink_en,
  input  logic [3:0]              i_brightness,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  logic [PW-1:0]           r_presc;
  logic [3:0]              r_sub;
  logic [IW-1:0]           r_idx;
  logic [BW-1:0]           r_bcnt;
  logic                    r_bphase;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp_l;
  logic                    r_blank_lz;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_tick;

  logic                    w_presc_wrap;
  logic                    w_sub_wrap;
  logic                    w_frame_end;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_zero_run;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_lit;

  assign w_presc_wrap = (r_presc == PRESC_MAX);
  assign w_sub_wrap   = w_presc_wrap && (r_sub == 4'hF);
  assign w_frame_end  = w_sub_wrap && (r_idx == IDX_MAX);

  // A digit is a leading zero when it and every higher latched nibble are zero.
  always_comb begin
    w_blank    = {NUM_DIGITS{1'b0}};
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_run = w_zero_run & (r_value[4*k +: 4] == 4'h0);
      w_blank[k] = r_blank_lz & w_zero_run;
    end
  end

  assign w_nib    = r_value[{r_idx, 2'b00} +: 4];
  assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
  assign w_lit    = (~i_blink_en | ~r_bphase) & ~w_blank[r_idx] & (r_sub <= i_brightness);

  // Scan counters, frame-start latching and blink phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc      <= {PW{1'b0}};
      r_sub        <= 4'h0;
      r_idx        <= {IW{1'b0}};
      r_bcnt       <= {BW{1'b0}};
      r_bphase     <= 1'b0;
      r_value      <= {(4*NUM_DIGITS){1'b0}};
      r_dp_l       <= {NUM_DIGITS{1'b0}};
      r_blank_lz   <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= w_presc_wrap ? {PW{1'b0}} : r_presc + 1'b1;
      r_frame_tick <= w_frame_end;
      if (w_presc_wrap) begin
        r_sub <= r_sub + 4'h1;
      end else begin
        r_sub <= r_sub;
      end
      if (w_sub_wrap) begin
        r_idx <= w_frame_end ? {IW{1'b0}} : r_idx + 1'b1;
      end else begin
        r_idx <= r_idx;
      end
      // Inputs are captured only at the frame boundary so a frame never tears.
      if (w_frame_end) begin
        r_value    <= i_display_value;
        r_dp_l     <= i_dp_in;
        r_blank_lz <= i_blank_lz;
      end else begin
        r_value    <= r_value;
        r_dp_l     <= r_dp_l;
        r_blank_lz <= r_blank_lz;
      end
      if (!i_blink_en) begin
        r_bcnt   <= {BW{1'b0}};
        r_bphase <= 1'b0;
      end else if (w_frame_end) begin
        if (r_bcnt == BLINK_MAX) begin
          r_bcnt   <= {BW{1'b0}};
          r_bphase <= ~r_bphase;
        end else begin
          r_bcnt   <= r_bcnt + 1'b1;
          r_bphase <= r_bphase;
        end
      end else begin
        r_bcnt   <= r_bcnt;
        r_bphase <= r_bphase;
      end
    end
  end

  // Registered pin drive; a dark slot forces segments and point off too.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_an  <= {NUM_DIGITS{1'b1}};
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_lit) begin
      r_an  <= ~w_onehot;
      r_seg <= hex7(w_nib);
      r_dp  <= ~r_dp_l[r_idx];
    end else begin
      r_an  <= {NUM_DIGITS{1'b1}};
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end
  end

  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed pins plus randomized inputs checked every cycle
// against a frame/time arithmetic model of the display.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 2;
  localparam int BF = 2;
  localparam int SLOT  = RD * 16;
  localparam int FRAME = SLOT * ND;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        ftick;

  int n_cmp = 0;
  int n_err = 0;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_display_value(value), .i_dp_in(dp_in),
    .i_blank_lz(blank_lz), .i_blink_en(blink_en), .i_brightness(bright),
    .o_an(an), .o_seg(seg), .o_dp(dp), .o_frame_tick(ftick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame comes from the cycle count since reset.
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          t;
  int          bk;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_ft;

  initial begin
    int idx, sub;
    bit fend, on, blank, lit;
    logic [3:0] one;
    one = 4'b0001;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        t = 0; bk = 0; m_val = 16'h0; m_dp = 4'h0; m_blz = 1'b0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
      end else begin
        idx   = (t / SLOT) % ND;
        sub   = (t / RD) % 16;
        fend  = ((t + 1) % FRAME) == 0;
        on    = !blink_en || ((bk / BF) % 2 == 0);
        blank = m_blz && idx > 0 && ((m_val >> (4 * idx)) == 16'h0);
        lit   = on && !blank && (sub <= int'(bright));
        e_an  = lit ? ~(one << idx) : 4'hF;
        e_seg = lit ? seg_tab[(m_val >> (4 * idx)) & 16'hF] : 7'h7F;
        e_dp  = lit ? ~m_dp[idx] : 1'b1;
        e_ft  = fend;
        if (fend) begin
          m_val = value; m_dp = dp_in; m_blz = blank_lz;
        end
        if (!blink_en) bk = 0;
        else if (fend) bk++;
        t++;
      end
      #1;
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("frame_tick", 32'(ftick), 32'(e_ft));
    end
  end

  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      @(posedge clk); #1;
      if (ftick) got = 1'b1;
    end
    chk("frame_tick_wait", 32'(got), 32'd1);
  endtask

  task automatic count_cycles(input int n, input int mode, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      case (mode)
        0: if (an[0] == 1'b0) cnt++;
        1: if (seg == 7'h24) cnt++;
        2: if (an != 4'hF) cnt++;
        3: if (an[3:1] != 3'b111) cnt++;
        default: cnt = cnt;
      endcase
    end
  endtask

  logic [3:0] x_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] x_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
  logic [6:0] z_seg [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
  logic [3:0] z_an  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};

  initial begin
    int cnt;
    logic [15:0] v;
    value = 16'h12AF; dp_in = 4'b0100; bright = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'd1);
    chk("reset_tick", 32'(ftick), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Walk of 16'h12AF at full brightness with point on digit 2.
    wait_tick();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SLOT; c++) begin
        @(posedge clk); #1;
        if (c == 0 || c == SLOT - 1) begin
          chk("walk_an", 32'(an), 32'(x_an[d]));
          chk("walk_seg", 32'(seg), 32'(x_seg[d]));
          chk("walk_dp", 32'(dp), (d == 2) ? 32'd0 : 32'd1);
        end
      end
    end

    // Leading-zero blanking.
    @(negedge clk); value = 16'h0050; blank_lz = 1'b1;
    wait_tick();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SLOT; c++) begin
        @(posedge clk); #1;
        if (c == 1) begin
          chk("lz_an", 32'(an), 32'(z_an[d]));
          chk("lz_seg", 32'(seg), 32'(z_seg[d]));
        end
      end
    end
    @(negedge clk); value = 16'h0000;
    wait_tick();
    count_cycles(FRAME, 3, cnt);
    chk("zero_only_digit0", 32'(cnt), 32'd0);

    // PWM duty.
    @(negedge clk); value = 16'h12AF; blank_lz = 1'b0; bright = 4'd3;
    wait_tick();
    count_cycles(SLOT, 0, cnt);
    chk("pwm_b3_low_clks", 32'(cnt), 32'd8);
    @(negedge clk); bright = 4'd0;
    wait_tick();
    count_cycles(SLOT, 0, cnt);
    chk("pwm_b0_low_clks", 32'(cnt), 32'd2);

    // No tearing on a mid-frame change.
    @(negedge clk); bright = 4'hF; value = 16'h1111;
    wait_tick();
    @(negedge clk); value = 16'h2222;
    count_cycles(FRAME, 1, cnt);
    chk("no_tear", 32'(cnt), 32'd0);
    count_cycles(FRAME, 1, cnt);
    chk("after_tick_shows_2", 32'(cnt), 32'(FRAME));

    // Blink: one more lit frame, then dark; disabling relights at once.
    @(negedge clk); blink_en = 1'b1;
    wait_tick();
    count_cycles(FRAME, 2, cnt);
    chk("blink_lit_frame", 32'(cnt), 32'(FRAME));
    count_cycles(FRAME / 2, 2, cnt);
    chk("blink_dark_frame", 32'(cnt), 32'd0);
    @(negedge clk); blink_en = 1'b0;
    @(posedge clk); #1;
    chk("blink_release_lit", 32'(an != 4'hF), 32'd1);

    // Asynchronous reset mid-slot.
    repeat (5) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_digit0", 32'(an), 32'b1110);
    chk("restart_seg0", 32'(seg), 32'h40);

    // Randomized phase, including one reset.
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < 4; k++)
          v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        value = v;
        dp_in = 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 49) == 0) bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) blink_en = ($urandom_range(0, 3) != 0);
      if (c == 4000) begin
        rst_n = 1'b0; #1;
        chk("rand_rst_an", 32'(an), 32'hF);
      end
      if (c == 4003) rst_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
